sync_fifo_fwft: RTL and testbench

//  Single-clock parametrised FIFO; next generation of the async FIFO for same-domain buffering.

---
 rtl/sync_fifo_fwft.sv | 121 ++++++++++++
 tb/tb_sync_fifo_fwft.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO with occupancy count, programmable almost flags, sticky error flags
// and a selectable first-word-fall-through read mode.
module sync_fifo_fwft #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 2
) (
    input  logic                  CLK,
    input  logic                  rst,
    input  logic                  W_inc,
    input  logic [DATA_WIDTH-1:0] W_Data,
    input  logic                  R_inc,
    input  logic                  Clr_Err,
    output logic [DATA_WIDTH-1:0] R_Data,
    output logic                  R_Valid,
    output logic                  Full,
    output logic                  Empty,
    output logic                  Almost_Full,
    output logic                  Almost_Empty,
    output logic [ADDR_WIDTH:0]   Level,
    output logic                  Overflow,
    output logic                  Underflow
);

    localparam int unsigned LW    = ADDR_WIDTH + 1;
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_L = LW'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_L    = LW'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_L    = LW'(AE_LEVEL);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  af_q, af_d;
    logic                  ae_q, ae_d;
    logic                  ovf_q, ovf_d;
    logic                  unf_q, unf_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;
    logic                  wr_en, rd_en;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr;

    assign wr_addr = wr_ptr_q[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[ADDR_WIDTH-1:0];

    always_comb begin
        wr_en    = W_inc & ~full_q;
        rd_en    = R_inc & ~empty_q;
        wr_ptr_d = wr_ptr_q + LW'(wr_en);
        rd_ptr_d = rd_ptr_q + LW'(rd_en);
        level_d  = level_q + LW'(wr_en) - LW'(rd_en);
        // Flags come from the next level so they track post-edge occupancy.
        full_d   = (level_d == DEPTH_L);
        empty_d  = (level_d == '0);
        af_d     = (level_d >= AF_L);
        ae_d     = (level_d <= AE_L);
        ovf_d    = (W_inc & full_q)  | (ovf_q & ~Clr_Err);
        unf_d    = (R_inc & empty_q) | (unf_q & ~Clr_Err);
        rdata_d  = rdata_q;
        if (rd_en) rdata_d = mem_q[rd_addr];
        rvalid_d = rd_en;
    end

    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            af_q     <= af_d;
            ae_q     <= ae_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_en) mem_q[wr_addr] <= W_Data;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // Gated while empty so the unreset memory never shows through after reset.
            assign R_Data  = empty_q ? '0 : mem_q[rd_addr];
            assign R_Valid = ~empty_q;
        end else begin : g_std
            assign R_Data  = rdata_q;
            assign R_Valid = rvalid_q;
        end
    endgenerate

    assign Full         = full_q;
    assign Empty        = empty_q;
    assign Almost_Full  = af_q;
    assign Almost_Empty = ae_q;
    assign Level        = level_q;
    assign Overflow     = ovf_q;
    assign Underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_fwft.sv
// Directed self-checking bench for sync_fifo_fwft: a standard-read instance and an FWFT instance.
module tb_sync_fifo_fwft;

    logic       clk = 1'b0;
    logic       rst;
    logic       w_inc, r_inc, clr;
    logic [7:0] w_data;
    logic [7:0] r_data;
    logic       r_valid, full, empty, afull, aempty, ovf, unf;
    logic [4:0] level;

    logic       w1_inc, r1_inc, clr1;
    logic [7:0] w1_data;
    logic [7:0] r1_data;
    logic       r1_valid, full1, empty1, afull1, aempty1, ovf1, unf1;
    logic [4:0] level1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(0), .AF_LEVEL(12), .AE_LEVEL(2)) u_std (
        .CLK(clk), .rst(rst), .W_inc(w_inc), .W_Data(w_data), .R_inc(r_inc), .Clr_Err(clr),
        .R_Data(r_data), .R_Valid(r_valid), .Full(full), .Empty(empty),
        .Almost_Full(afull), .Almost_Empty(aempty), .Level(level),
        .Overflow(ovf), .Underflow(unf)
    );

    sync_fifo_fwft #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .FWFT(1), .AF_LEVEL(12), .AE_LEVEL(2)) u_fwft (
        .CLK(clk), .rst(rst), .W_inc(w1_inc), .W_Data(w1_data), .R_inc(r1_inc), .Clr_Err(clr1),
        .R_Data(r1_data), .R_Valid(r1_valid), .Full(full1), .Empty(empty1),
        .Almost_Full(afull1), .Almost_Empty(aempty1), .Level(level1),
        .Overflow(ovf1), .Underflow(unf1)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " level"},  32'(level),   32'd0);
        check({tag, " empty"},  32'(empty),   32'd1);
        check({tag, " full"},   32'(full),    32'd0);
        check({tag, " aempty"}, 32'(aempty),  32'd1);
        check({tag, " afull"},  32'(afull),   32'd0);
        check({tag, " rdata"},  32'(r_data),  32'd0);
        check({tag, " rvalid"}, 32'(r_valid), 32'd0);
        check({tag, " ovf"},    32'(ovf),     32'd0);
        check({tag, " unf"},    32'(unf),     32'd0);
    endtask

    initial begin
        rst = 1'b1;
        w_inc = 1'b0; r_inc = 1'b0; clr = 1'b0; w_data = '0;
        w1_inc = 1'b0; r1_inc = 1'b0; clr1 = 1'b0; w1_data = '0;
        repeat (2) tick();
        check_reset_outputs("reset");
        check("fwft reset rvalid", 32'(r1_valid), 32'd0);
        check("fwft reset empty",  32'(empty1),   32'd1);
        rst = 1'b0;

        // 1: fill 16 words, then drain in order
        for (int i = 1; i <= 16; i++) begin
            w_inc = 1'b1; w_data = 8'(i);
            tick();
            check("t1 wr level",  32'(level), 32'(i));
            check("t1 wr afull",  32'(afull), 32'(i >= 12));
            check("t1 wr aempty", 32'(aempty), 32'(i <= 2));
            check("t1 wr full",   32'(full), 32'(i == 16));
        end
        w_inc = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            r_inc = 1'b1;
            tick();
            check("t1 rd data",   32'(r_data),  32'(i));
            check("t1 rd valid",  32'(r_valid), 32'd1);
            check("t1 rd level",  32'(level),   32'(16 - i));
        end
        r_inc = 1'b0;
        tick();
        check("t1 valid pulse", 32'(r_valid), 32'd0);
        check("t1 empty",       32'(empty),   32'd1);
        check("t1 rdata hold",  32'(r_data),  32'h10);

        // 2: overflow, set-wins, full+write+read
        for (int i = 1; i <= 16; i++) begin
            w_inc = 1'b1; w_data = 8'(8'h20 + i);
            tick();
        end
        w_data = 8'hAA;
        tick();
        check("t2 ovf set",    32'(ovf),   32'd1);
        check("t2 ovf level",  32'(level), 32'd16);
        clr = 1'b1;
        tick();
        check("t2 set wins",   32'(ovf),   32'd1);
        w_inc = 1'b0;
        tick();
        check("t2 ovf clear",  32'(ovf),   32'd0);
        clr = 1'b0;
        w_inc = 1'b1; r_inc = 1'b1;
        tick();
        check("t2 fwr level",  32'(level),  32'd15);
        check("t2 fwr data",   32'(r_data), 32'h21);
        check("t2 fwr ovf",    32'(ovf),    32'd1);
        check("t2 fwr full",   32'(full),   32'd0);
        w_inc = 1'b0; clr = 1'b1;
        for (int i = 2; i <= 16; i++) begin
            tick();
            clr = 1'b0;
            check("t2 rd data", 32'(r_data), 32'(8'h20 + i));
        end
        r_inc = 1'b0;
        tick();
        check("t2 empty", 32'(empty), 32'd1);
        check("t2 ovf off", 32'(ovf), 32'd0);

        // 3: empty + write + read
        w_inc = 1'b1; r_inc = 1'b1; w_data = 8'h55;
        tick();
        check("t3 level",  32'(level),   32'd1);
        check("t3 unf",    32'(unf),     32'd1);
        check("t3 rvalid", 32'(r_valid), 32'd0);
        w_inc = 1'b0;
        tick();
        check("t3 data",   32'(r_data),  32'h55);
        check("t3 valid",  32'(r_valid), 32'd1);
        check("t3 empty",  32'(empty),   32'd1);
        r_inc = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0;
        check("t3 unf clear", 32'(unf), 32'd0);

        // 4: steady-state streaming at level 8 across pointer wrap
        for (int k = 0; k < 8; k++) begin
            w_inc = 1'b1; w_data = 8'(8'h80 + k);
            tick();
        end
        check("t4 fill level", 32'(level), 32'd8);
        r_inc = 1'b1;
        for (int j = 0; j < 40; j++) begin
            w_data = 8'(8'h88 + j);
            tick();
            check("t4 data",  32'(r_data), 32'(8'h80 + j));
            check("t4 level", 32'(level),  32'd8);
        end
        w_inc = 1'b0;
        for (int k = 0; k < 8; k++) begin
            tick();
            check("t4 drain", 32'(r_data), 32'(8'hA8 + k));
        end
        r_inc = 1'b0;
        tick();
        check("t4 empty", 32'(empty), 32'd1);
        check("t4 ovf",   32'(ovf),   32'd0);
        check("t4 unf",   32'(unf),   32'd0);

        // 5: FWFT instance
        w1_inc = 1'b1; w1_data = 8'h3C;
        tick();
        w1_inc = 1'b0;
        check("t5 data",  32'(r1_data),  32'h3C);
        check("t5 valid", 32'(r1_valid), 32'd1);
        tick();
        check("t5 hold",  32'(r1_data),  32'h3C);
        r1_inc = 1'b1;
        tick();
        r1_inc = 1'b0;
        check("t5 empty", 32'(empty1),   32'd1);
        check("t5 novalid", 32'(r1_valid), 32'd0);
        w1_inc = 1'b1; w1_data = 8'h11;
        tick();
        w1_data = 8'h22;
        tick();
        w1_inc = 1'b0; r1_inc = 1'b1;
        check("t5 head1", 32'(r1_data), 32'h11);
        tick();
        r1_inc = 1'b0;
        check("t5 head2", 32'(r1_data), 32'h22);
        check("t5 level", 32'(level1),  32'd1);

        // 6: asynchronous reset mid-stream
        for (int k = 1; k <= 6; k++) begin
            w_inc = 1'b1; w_data = 8'(8'h60 + k);
            tick();
        end
        w_inc = 1'b0; r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
        check("t6 pre data",  32'(r_data), 32'h61);
        check("t6 pre level", 32'(level),  32'd5);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("t6 async");
        tick();
        rst = 1'b0;
        w_inc = 1'b1; w_data = 8'h77;
        tick();
        w_inc = 1'b0; r_inc = 1'b1;
        tick();
        r_inc = 1'b0;
        check("t6 data",  32'(r_data),  32'h77);
        check("t6 valid", 32'(r_valid), 32'd1);
        check("t6 empty", 32'(empty),   32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
